// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU between two requesters.
// One operation is in flight at a time: accept (IDLE), execute (EXEC), respond (RESP).
module alu_arbiter #(
    parameter int WIDTH = 64,
    parameter int NREQ  = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [NREQ-1:0]  req_valid,
    output logic [NREQ-1:0]  req_ready,
    input  logic [WIDTH-1:0] req_A0,
    input  logic [WIDTH-1:0] req_B0,
    input  logic [WIDTH-1:0] req_A1,
    input  logic [WIDTH-1:0] req_B1,
    input  logic [4:0]       req_FS0,
    input  logic [4:0]       req_FS1,
    output logic [NREQ-1:0]  rsp_valid,
    input  logic [NREQ-1:0]  rsp_ready,
    output logic [WIDTH-1:0] rsp_F,
    output logic [3:0]       rsp_status,
    output logic [WIDTH-1:0] alu_A,
    output logic [WIDTH-1:0] alu_B,
    output logic [4:0]       alu_FS,
    input  logic [WIDTH-1:0] alu_F,
    input  logic [3:0]       alu_status
);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_RESP = 2'b10
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_last_grant;
    logic             r_owner;
    logic [WIDTH-1:0] r_op_A;
    logic [WIDTH-1:0] r_op_B;
    logic [4:0]       r_op_FS;
    logic [WIDTH-1:0] r_res_F;
    logic [3:0]       r_res_status;
    logic             w_grant;
    logic             w_req_hs;

    // A lone requester wins outright; on contention the pointer alternates.
    always_comb begin
        if (req_valid[0] && req_valid[1]) begin
            w_grant = ~r_last_grant;
        end else begin
            w_grant = req_valid[1];
        end
    end

    always_comb begin
        w_next    = r_state;
        req_ready = '0;
        rsp_valid = '0;
        w_req_hs  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (reset) begin
                    req_ready[w_grant] = req_valid[w_grant];
                    if (req_valid[w_grant]) begin
                        w_req_hs = 1'b1;
                        w_next   = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                w_next = S_RESP;
            end
            S_RESP: begin
                if (reset) begin
                    rsp_valid[r_owner] = 1'b1;
                    if (rsp_ready[r_owner]) begin
                        w_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_owner      <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_req_hs) begin
                r_last_grant <= w_grant;
                r_owner      <= w_grant;
            end
        end
    end

    // Operands change only on acceptance, so the ALU inputs are frozen through EXEC and RESP.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_op_A       <= '0;
            r_op_B       <= '0;
            r_op_FS      <= '0;
            r_res_F      <= '0;
            r_res_status <= '0;
        end else begin
            if (w_req_hs) begin
                r_op_A  <= w_grant ? req_A1  : req_A0;
                r_op_B  <= w_grant ? req_B1  : req_B0;
                r_op_FS <= w_grant ? req_FS1 : req_FS0;
            end
            if (r_state == S_EXEC) begin
                r_res_F      <= alu_F;
                r_res_status <= alu_status;
            end
        end
    end

    assign alu_A      = r_op_A;
    assign alu_B      = r_op_B;
    assign alu_FS     = r_op_FS;
    assign rsp_F      = r_res_F;
    assign rsp_status = r_res_status;

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-level model (pending queues, one in-flight operation).
module tb_alu_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [63:0] req_A0, req_B0, req_A1, req_B1;
    logic [4:0]  req_FS0, req_FS1;
    logic [63:0] rsp_F, alu_A, alu_B, alu_F;
    logic [3:0]  rsp_status, alu_status;
    logic [4:0]  alu_FS;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  fs;
    } op_t;

    typedef struct {
        op_t  op;
        logic own;
        int   acc;
    } fl_t;

    op_t         q0[$];
    op_t         q1[$];
    fl_t         fl[$];
    logic        grant_log[$];
    int          acc_cyc[$];
    int          rsp_cyc[$];
    logic [63:0] f_log[$];
    logic        m_last;

    always #5 clock = ~clock;

    alu_arbiter #(.WIDTH(64), .NREQ(2)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_A0(req_A0), .req_B0(req_B0), .req_A1(req_A1), .req_B1(req_B1),
        .req_FS0(req_FS0), .req_FS1(req_FS1),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_F(rsp_F), .rsp_status(rsp_status),
        .alu_A(alu_A), .alu_B(alu_B), .alu_FS(alu_FS),
        .alu_F(alu_F), .alu_status(alu_status)
    );

    function automatic logic [63:0] alu_fn(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs);
        case (fs[4:2])
            3'd0:    return a & b;
            3'd1:    return a | b;
            3'd2:    return a + b;
            3'd3:    return a ^ b;
            3'd4:    return a << b[5:0];
            3'd5:    return a >> b[5:0];
            3'd6:    return a - b;
            default: return ~a;
        endcase
    endfunction

    function automatic logic [3:0] alu_st(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs);
        logic [63:0] f;
        f = alu_fn(a, b, fs);
        return {f[63], f == 64'd0, ^f, fs[0]};
    endfunction

    // Stand-in ALU: purely combinational from the DUT's operand registers.
    always_comb begin
        alu_F      = alu_fn(alu_A, alu_B, alu_FS);
        alu_status = alu_st(alu_A, alu_B, alu_FS);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
        cyc++;
    endtask

    function automatic op_t mk(input logic [63:0] a, input logic [63:0] b, input logic [4:0] fs);
        op_t o;
        o.a = a; o.b = b; o.fs = fs;
        return o;
    endfunction

    function automatic op_t rand_op();
        op_t o;
        o.a  = {$urandom, $urandom};
        o.b  = ($urandom_range(1) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
        o.fs = 5'($urandom);
        return o;
    endfunction

    task automatic drive_ops();
        req_valid = {q1.size() != 0, q0.size() != 0};
        req_A0  = (q0.size() != 0) ? q0[0].a  : 64'd0;
        req_B0  = (q0.size() != 0) ? q0[0].b  : 64'd0;
        req_FS0 = (q0.size() != 0) ? q0[0].fs : 5'd0;
        req_A1  = (q1.size() != 0) ? q1[0].a  : 64'd0;
        req_B1  = (q1.size() != 0) ? q1[0].b  : 64'd0;
        req_FS1 = (q1.size() != 0) ? q1[0].fs : 5'd0;
    endtask

    task automatic clear_logs();
        grant_log.delete(); acc_cyc.delete(); rsp_cyc.delete(); f_log.delete();
    endtask

    // Transaction-level reference: at most one op in flight; response two cycles
    // after acceptance; grant by round-robin among requesters with pending work.
    task automatic run_engine(input int max_cyc, input bit rnd, input int gen);
        bit   done;
        logic g;
        fl_t  f;
        op_t  o;
        done = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (rnd) begin
                if (c < gen) begin
                    if ($urandom_range(3) == 0 && q0.size() < 2) q0.push_back(rand_op());
                    if ($urandom_range(3) == 0 && q1.size() < 2) q1.push_back(rand_op());
                end
                rsp_ready = 2'($urandom);
            end
            if ((!rnd || c >= gen) && q0.size() == 0 && q1.size() == 0 && fl.size() == 0) begin
                done = 1'b1;
                break;
            end
            drive_ops();
            #1;
            if (fl.size() != 0) begin
                o = fl[0].op;
                chk("busy_req_ready", 64'(req_ready), 64'd0);
                chk("rsp_valid", 64'(rsp_valid), (cyc - fl[0].acc >= 2) ? 64'(2'b01 << fl[0].own) : 64'd0);
                chk("alu_A_hold", alu_A, o.a);
                chk("alu_FS_hold", 64'(alu_FS), 64'(o.fs));
                if (cyc - fl[0].acc >= 2) begin
                    chk("rsp_F", rsp_F, alu_fn(o.a, o.b, o.fs));
                    chk("rsp_status", 64'(rsp_status), 64'(alu_st(o.a, o.b, o.fs)));
                    if (rsp_ready[fl[0].own]) begin
                        rsp_cyc.push_back(cyc);
                        f_log.push_back(rsp_F);
                        void'(fl.pop_front());
                    end
                end
            end else begin
                chk("idle_rsp_valid", 64'(rsp_valid), 64'd0);
                if (req_valid == 2'b00) begin
                    chk("idle_req_ready", 64'(req_ready), 64'd0);
                end else begin
                    g = (req_valid == 2'b11) ? ~m_last : req_valid[1];
                    chk("grant", 64'(req_ready), 64'(2'b01 << g));
                    f.own = g;
                    f.acc = cyc;
                    f.op  = g ? q1.pop_front() : q0.pop_front();
                    fl.push_back(f);
                    m_last = g;
                    grant_log.push_back(g);
                    acc_cyc.push_back(cyc);
                end
            end
            tick();
        end
        chk("engine_timeout", 64'(done), 64'd1);
    endtask

    initial begin
        reset = 1'b0; rsp_ready = 2'b00; req_valid = 2'b00;
        req_A0 = '0; req_B0 = '0; req_FS0 = '0; req_A1 = '0; req_B1 = '0; req_FS1 = '0;
        m_last = 1'b1;

        // Single request (AND), including reset-cycle behaviour
        @(negedge clock);
        req_valid = 2'b01; req_A0 = 64'd2; req_B0 = 64'd5; req_FS0 = 5'b00000;
        #1;
        chk("rst_req_ready", 64'(req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("rst_alu_A", alu_A, 64'd0);
        chk("rst_alu_FS", 64'(alu_FS), 64'd0);
        chk("rst_rsp_F", rsp_F, 64'd0);
        chk("rst_rsp_status", 64'(rsp_status), 64'd0);
        chk("rst_req_ready_hold", 64'(req_ready), 64'd0);
        reset = 1'b1; rsp_ready = 2'b11;
        #1;
        chk("and_c0_ready", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b00;
        #1;
        chk("and_c1_alu_FS", 64'(alu_FS), 64'd0);
        chk("and_c1_alu_A", alu_A, 64'd2);
        chk("and_c1_alu_B", alu_B, 64'd5);
        chk("and_c1_ready", 64'(req_ready), 64'd0);
        chk("and_c1_rsp_valid", 64'(rsp_valid), 64'd0);
        tick();
        chk("and_c2_rsp_valid", 64'(rsp_valid), 64'd1);
        chk("and_c2_rsp_F", rsp_F, 64'd0);
        chk("and_c2_status", 64'(rsp_status), 64'(alu_st(64'd2, 64'd5, 5'b00000)));
        tick();

        // Contention right after reset: requester 0 first
        reset = 1'b0; tick(); reset = 1'b1; m_last = 1'b1;
        req_A0 = 64'd1; req_B0 = 64'd15; req_FS0 = 5'b01000;
        req_A1 = 64'd3; req_B1 = 64'd6;  req_FS1 = 5'b01100;
        req_valid = 2'b11;
        #1;
        chk("cont_first_grant", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b10;
        #1;
        chk("cont_exec_ready", 64'(req_ready), 64'd0);
        tick();
        chk("cont_rsp0_valid", 64'(rsp_valid), 64'd1);
        chk("cont_rsp0_F", rsp_F, 64'd16);
        tick();
        chk("cont_second_grant", 64'(req_ready), 64'd2);
        tick();
        req_valid = 2'b00;
        tick();
        chk("cont_rsp1_valid", 64'(rsp_valid), 64'd2);
        chk("cont_rsp1_F", rsp_F, 64'd5);
        chk("cont_rsp1_status", 64'(rsp_status), 64'(alu_st(64'd3, 64'd6, 5'b01100)));
        tick();

        // Sustained contention: 0,1,0,1,0,1 with responses 3 cycles apart
        clear_logs();
        for (int i = 0; i < 3; i++) begin
            q0.push_back(rand_op());
            q1.push_back(rand_op());
        end
        rsp_ready = 2'b11;
        run_engine(60, 1'b0, 0);
        chk("sust_count", 64'(grant_log.size()), 64'd6);
        for (int i = 0; i < 6; i++) begin
            if (i < grant_log.size()) chk("sust_order", 64'(grant_log[i]), 64'(i % 2));
            if (i > 0 && i < rsp_cyc.size()) chk("sust_spacing", 64'(rsp_cyc[i] - rsp_cyc[i-1]), 64'd3);
        end

        // Backpressure on requester 0 while requester 1 waits
        req_A0 = 64'd2; req_B0 = 64'd5; req_FS0 = 5'b00100;
        req_A1 = 64'd9; req_B1 = 64'd3; req_FS1 = 5'b01000;
        req_valid = 2'b11; rsp_ready = 2'b10;
        #1;
        chk("bp_grant0", 64'(req_ready), 64'd1);
        tick();
        req_valid = 2'b10;
        tick();
        for (int i = 0; i < 4; i++) begin
            chk("bp_rsp_valid", 64'(rsp_valid), 64'd1);
            chk("bp_rsp_F", rsp_F, 64'd7);
            chk("bp_req_ready", 64'(req_ready), 64'd0);
            chk("bp_alu_A", alu_A, 64'd2);
            chk("bp_alu_B", alu_B, 64'd5);
            chk("bp_alu_FS", 64'(alu_FS), 64'd4);
            tick();
        end
        rsp_ready = 2'b01;
        #1;
        chk("bp_rsp_valid_last", 64'(rsp_valid), 64'd1);
        tick();
        chk("bp_req1_accept", 64'(req_ready), 64'd2);
        tick();

        // Reset during EXEC abandons the operation
        req_valid = 2'b00; reset = 1'b0;
        #1;
        chk("rexec_rsp_valid", 64'(rsp_valid), 64'd0);
        chk("rexec_req_ready", 64'(req_ready), 64'd0);
        tick();
        reset = 1'b1;
        #1;
        chk("rexec_alu_A", alu_A, 64'd0);
        chk("rexec_alu_B", alu_B, 64'd0);
        chk("rexec_alu_FS", 64'(alu_FS), 64'd0);
        chk("rexec_rsp_F", rsp_F, 64'd0);
        for (int i = 0; i < 3; i++) begin
            chk("rexec_no_rsp", 64'(rsp_valid), 64'd0);
            tick();
        end
        m_last = 1'b1; rsp_ready = 2'b11;
        clear_logs();
        q0.push_back(rand_op());
        q1.push_back(rand_op());
        run_engine(30, 1'b0, 0);
        chk("rexec_next_grant_count", 64'(grant_log.size()), 64'd2);
        if (grant_log.size() > 0) chk("rexec_next_grant", 64'(grant_log[0]), 64'd0);

        // Lone requester 1, back-to-back
        clear_logs();
        q1.push_back(mk(64'd1, 64'd1, 5'b10000));
        q1.push_back(mk(64'd1, 64'd1, 5'b10100));
        q1.push_back(mk(64'd1, 64'd1, 5'b10000));
        run_engine(40, 1'b0, 0);
        chk("lone_count", 64'(f_log.size()), 64'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < grant_log.size()) chk("lone_grant", 64'(grant_log[i]), 64'd1);
            if (i > 0 && i < acc_cyc.size()) chk("lone_spacing", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd3);
        end
        if (f_log.size() == 3) begin
            chk("lone_F0", f_log[0], 64'd2);
            chk("lone_F1", f_log[1], 64'd0);
            chk("lone_F2", f_log[2], 64'd2);
        end

        // Randomized traffic with random response backpressure
        reset = 1'b0; req_valid = 2'b00; tick(); reset = 1'b1; m_last = 1'b1;
        clear_logs();
        run_engine(1500, 1'b1, 400);
        chk("rand_some_ops", 64'(grant_log.size() > 20), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
